// File: rtl/tb_turbo_encoder.sv
// Rate-1/3 LTE turbo encoder (two 8-state RSC + QPP interleaver): buffers K bits, then emits K+6 symbols.
// First symbol valid one cycle after the last bit is accepted; symbol outputs hold while sym_ready_i is low.
module tb_turbo_encoder #(
   parameter int K_MAX  = 512,
   parameter int ADDR_W = $clog2(K_MAX) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] blk_len_i,
   input  logic [ADDR_W-1:0] f1_i,
   input  logic [ADDR_W-1:0] f2_i,
   input  logic              bit_valid_i,
   input  logic              bit_i,
   output logic              bit_ready_o,
   output logic              sym_valid_o,
   input  logic              sym_ready_i,
   output logic [2:0]        sym_o,
   output logic              sym_tail_o,
   output logic              sym_last_o,
   output logic              err_o,
   output logic              busy_o
);

   localparam int IDX_W = $clog2(K_MAX);
   localparam logic [ADDR_W-1:0] MIN_LEN = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(K_MAX);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENC, S_TAIL1, S_TAIL2} state_t;

   state_t            state_q;
   logic [K_MAX-1:0]  buf_q;
   logic [ADDR_W-1:0] k_q, f1_q, f2_q, f2x2_q;
   logic [ADDR_W-1:0] wr_cnt_q, i_q, pi_q, g_q;
   logic [2:0]        s1_q, s2_q;
   logic [1:0]        tcnt_q;
   logic              err_q;

   logic              accept, len_ok, u, up;
   logic              a1, z1, a2, z2, x1t, z1t, x2t, z2t;
   logic [IDX_W-1:0]  wr_addr;

   // Sum of two residues needs only one conditional subtract to stay in [0, m).
   function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] m);
      logic [ADDR_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m})
         s = s - {1'b0, m};
      return s[ADDR_W-1:0];
   endfunction

   assign bit_ready_o = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign sym_valid_o = (state_q == S_ENC) || (state_q == S_TAIL1) || (state_q == S_TAIL2);
   assign busy_o      = (state_q != S_IDLE);
   assign err_o       = err_q;
   assign accept      = bit_valid_i && bit_ready_o;
   assign len_ok      = (blk_len_i >= MIN_LEN) && (blk_len_i <= MAX_LEN);
   assign wr_addr     = (state_q == S_IDLE) ? '0 : wr_cnt_q[IDX_W-1:0];

   assign u   = buf_q[i_q[IDX_W-1:0]];
   assign up  = buf_q[pi_q[IDX_W-1:0]];
   assign a1  = u  ^ s1_q[1] ^ s1_q[2];
   assign z1  = a1 ^ s1_q[0] ^ s1_q[2];
   assign a2  = up ^ s2_q[1] ^ s2_q[2];
   assign z2  = a2 ^ s2_q[0] ^ s2_q[2];
   // Termination: feedback bit as input forces a=0, flushing the register.
   assign x1t = s1_q[1] ^ s1_q[2];
   assign z1t = s1_q[0] ^ s1_q[2];
   assign x2t = s2_q[1] ^ s2_q[2];
   assign z2t = s2_q[0] ^ s2_q[2];

   always_comb begin
      sym_o      = 3'b000;
      sym_tail_o = 1'b0;
      sym_last_o = 1'b0;
      case (state_q)
         S_ENC:   sym_o = {z2, z1, u};
         S_TAIL1: begin
            sym_o      = {1'b0, z1t, x1t};
            sym_tail_o = 1'b1;
         end
         S_TAIL2: begin
            sym_o      = {1'b0, z2t, x2t};
            sym_tail_o = 1'b1;
            sym_last_o = (tcnt_q == 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (accept)
         buf_q[wr_addr] <= bit_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         f1_q     <= '0;
         f2_q     <= '0;
         f2x2_q   <= '0;
         wr_cnt_q <= '0;
         i_q      <= '0;
         pi_q     <= '0;
         g_q      <= '0;
         s1_q     <= 3'b000;
         s2_q     <= 3'b000;
         tcnt_q   <= 2'd0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bit_valid_i) begin
                  k_q  <= blk_len_i;
                  f1_q <= f1_i;
                  f2_q <= f2_i;
                  if (len_ok) begin
                     wr_cnt_q <= ONE;
                     state_q  <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bit_valid_i) begin
                  wr_cnt_q <= wr_cnt_q + ONE;
                  if (wr_cnt_q == k_q - ONE) begin
                     state_q <= S_ENC;
                     i_q     <= '0;
                     pi_q    <= '0;
                     g_q     <= mod_add(f1_q, f2_q, k_q);
                     f2x2_q  <= mod_add(f2_q, f2_q, k_q);
                     s1_q    <= 3'b000;
                     s2_q    <= 3'b000;
                  end
               end
            end
            S_ENC: begin
               if (sym_ready_i) begin
                  s1_q <= {s1_q[1:0], a1};
                  s2_q <= {s2_q[1:0], a2};
                  i_q  <= i_q + ONE;
                  pi_q <= mod_add(pi_q, g_q, k_q);
                  g_q  <= mod_add(g_q, f2x2_q, k_q);
                  if (i_q == k_q - ONE) begin
                     state_q <= S_TAIL1;
                     tcnt_q  <= 2'd0;
                  end
               end
            end
            S_TAIL1: begin
               if (sym_ready_i) begin
                  s1_q   <= {s1_q[1:0], 1'b0};
                  tcnt_q <= tcnt_q + 2'd1;
                  if (tcnt_q == 2'd2) begin
                     state_q <= S_TAIL2;
                     tcnt_q  <= 2'd0;
                  end
               end
            end
            S_TAIL2: begin
               if (sym_ready_i) begin
                  s2_q   <= {s2_q[1:0], 1'b0};
                  tcnt_q <= tcnt_q + 2'd1;
                  if (tcnt_q == 2'd2) begin
                     state_q <= S_IDLE;
                     tcnt_q  <= 2'd0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tb_turbo_encoder.sv
// Directed bench for the turbo encoder: reset, zero/impulse blocks, interleaver, stalls, mid-block reset, bad length.
module tb_tb_turbo_encoder;

   localparam int K_MAX = 512;
   localparam int AW    = $clog2(K_MAX) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [AW-1:0] blk_len_i = '0;
   logic [AW-1:0] f1_i = '0;
   logic [AW-1:0] f2_i = '0;
   logic          bit_valid_i = 1'b0;
   logic          bit_i = 1'b0;
   logic          bit_ready_o;
   logic          sym_valid_o;
   logic          sym_ready_i = 1'b0;
   logic [2:0]    sym_o;
   logic          sym_tail_o;
   logic          sym_last_o;
   logic          err_o;
   logic          busy_o;

   int vec  = 0;
   int errs = 0;

   logic       blk      [0:K_MAX-1];
   logic [2:0] exp_sym  [0:K_MAX+5];
   logic       exp_tail [0:K_MAX+5];
   logic       exp_last [0:K_MAX+5];
   logic [2:0] got_sym  [0:K_MAX+5];
   logic       got_tail [0:K_MAX+5];
   logic       got_last [0:K_MAX+5];

   tb_turbo_encoder #(.K_MAX(K_MAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .blk_len_i(blk_len_i), .f1_i(f1_i), .f2_i(f2_i),
      .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(bit_ready_o),
      .sym_valid_o(sym_valid_o), .sym_ready_i(sym_ready_i), .sym_o(sym_o),
      .sym_tail_o(sym_tail_o), .sym_last_o(sym_last_o), .err_o(err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: interleaver from the closed-form QPP polynomial, RSC from the generator equations.
   function automatic void build_model(input int k, input int f1, input int f2);
      logic [2:0] s1, s2;
      logic       u, up, a, z, a2, z2;
      int         p;
      s1 = 3'b000;
      s2 = 3'b000;
      for (int i = 0; i < k; i++) begin
         p  = (f1 * i + f2 * i * i) % k;
         u  = blk[i];
         up = blk[p];
         a  = u ^ s1[1] ^ s1[2];
         z  = a ^ s1[0] ^ s1[2];
         a2 = up ^ s2[1] ^ s2[2];
         z2 = a2 ^ s2[0] ^ s2[2];
         s1 = {s1[1:0], a};
         s2 = {s2[1:0], a2};
         exp_sym[i] = {z2, z, u};
         exp_tail[i] = 1'b0;
         exp_last[i] = 1'b0;
      end
      for (int t = 0; t < 3; t++) begin
         exp_sym[k+t]  = {1'b0, s1[0] ^ s1[2], s1[1] ^ s1[2]};
         exp_tail[k+t] = 1'b1;
         exp_last[k+t] = 1'b0;
         s1 = {s1[1:0], 1'b0};
      end
      for (int t = 0; t < 3; t++) begin
         exp_sym[k+3+t]  = {1'b0, s2[0] ^ s2[2], s2[1] ^ s2[2]};
         exp_tail[k+3+t] = 1'b1;
         exp_last[k+3+t] = (t == 2);
         s2 = {s2[1:0], 1'b0};
      end
   endfunction

   task automatic fill_blk(input int mode);
      for (int n = 0; n < K_MAX; n++)
         blk[n] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // Leaves the bench at the negedge right after the last bit was accepted.
   task automatic send_block(input int k, input int f1, input int f2);
      for (int n = 0; n < k; n++) begin
         @(negedge clk_i);
         bit_valid_i = 1'b1;
         bit_i       = blk[n];
         blk_len_i   = AW'(k);
         f1_i        = AW'(f1);
         f2_i        = AW'(f2);
      end
      @(negedge clk_i);
      bit_valid_i = 1'b0;
      bit_i       = 1'b0;
   endtask

   task automatic collect(input int n, input bit stall, output int got,
                          output int viol, output int stalls);
      int         stall_left = 0;
      int         cyc = 0;
      bit         holding = 1'b0;
      logic [4:0] held = '0;
      got = 0;
      viol = 0;
      stalls = 0;
      while (got < n && cyc < 5000) begin
         if (stall_left > 0) begin
            sym_ready_i = 1'b0;
            stall_left--;
         end else begin
            sym_ready_i = 1'b1;
         end
         if (sym_valid_o) begin
            if (holding) begin
               stalls++;
               if ({sym_o, sym_tail_o, sym_last_o} !== held)
                  viol++;
            end
            if (sym_ready_i) begin
               got_sym[got]  = sym_o;
               got_tail[got] = sym_tail_o;
               got_last[got] = sym_last_o;
               got++;
               holding = 1'b0;
               if (stall)
                  stall_left = $urandom_range(0, 5);
            end else begin
               holding = 1'b1;
               held    = {sym_o, sym_tail_o, sym_last_o};
            end
         end
         @(negedge clk_i);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      vec++;
      if ({bit_ready_o, sym_valid_o, busy_o, err_o, sym_tail_o, sym_last_o} !== 6'b100000) begin
         errs++;
         $display("FAIL reset_outputs: got %b expected 100000",
                  {bit_ready_o, sym_valid_o, busy_o, err_o, sym_tail_o, sym_last_o});
      end
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_zero_block();
      int got, viol, stalls;
      fill_blk(0);
      send_block(40, 3, 10);
      vec++;
      if (sym_valid_o !== 1'b1) begin
         errs++;
         $display("FAIL zero_first_valid: got %b expected 1", sym_valid_o);
      end
      collect(46, 1'b0, got, viol, stalls);
      vec++;
      if (got !== 46) begin
         errs++;
         $display("FAIL zero_count: got %0d expected 46", got);
      end
      for (int i = 0; i < got; i++) begin
         vec++;
         if ({got_sym[i], got_tail[i], got_last[i]} !== {3'b000, i >= 40, i == 45}) begin
            errs++;
            $display("FAIL zero_sym[%0d]: got %b expected %b", i,
                     {got_sym[i], got_tail[i], got_last[i]}, {3'b000, i >= 40, i == 45});
         end
      end
      vec++;
      if ({sym_valid_o, busy_o, bit_ready_o} !== 3'b001) begin
         errs++;
         $display("FAIL zero_idle_after: got %b expected 001", {sym_valid_o, busy_o, bit_ready_o});
      end
   endtask

   task automatic test_impulse();
      int got, viol, stalls;
      fill_blk(0);
      blk[0] = 1'b1;
      build_model(40, 3, 10);
      send_block(40, 3, 10);
      collect(46, 1'b0, got, viol, stalls);
      vec++;
      if (got_sym[0] !== 3'b111 || got_sym[1] !== 3'b110) begin
         errs++;
         $display("FAIL impulse_head: got %b %b expected 111 110", got_sym[0], got_sym[1]);
      end
      for (int i = 0; i < 46; i++) begin
         vec++;
         if ({got_sym[i], got_tail[i], got_last[i]} !== {exp_sym[i], exp_tail[i], exp_last[i]}) begin
            errs++;
            $display("FAIL impulse_sym[%0d]: got %b expected %b", i,
                     {got_sym[i], got_tail[i], got_last[i]}, {exp_sym[i], exp_tail[i], exp_last[i]});
         end
      end
   endtask

   // A single 1 at buffer index 13 (then 6) must reach encoder 2 at i=1 (then i=2): pi = 0, 13, 6.
   task automatic test_interleaver();
      int got, viol, stalls;
      fill_blk(0);
      blk[13] = 1'b1;
      send_block(40, 3, 10);
      collect(46, 1'b0, got, viol, stalls);
      vec++;
      if (got_sym[0] !== 3'b000 || got_sym[1] !== 3'b100) begin
         errs++;
         $display("FAIL pi_1: got %b %b expected 000 100", got_sym[0], got_sym[1]);
      end
      fill_blk(0);
      blk[6] = 1'b1;
      send_block(40, 3, 10);
      collect(46, 1'b0, got, viol, stalls);
      vec++;
      if (got_sym[1] !== 3'b000 || got_sym[2] !== 3'b100) begin
         errs++;
         $display("FAIL pi_2: got %b %b expected 000 100", got_sym[1], got_sym[2]);
      end
   endtask

   task automatic test_stall();
      int got, viol, stalls;
      fill_blk(1);
      build_model(40, 3, 10);
      for (int pass = 0; pass < 2; pass++) begin
         send_block(40, 3, 10);
         collect(46, pass == 1, got, viol, stalls);
         vec++;
         if (got !== 46) begin
            errs++;
            $display("FAIL stall_count pass %0d: got %0d expected 46", pass, got);
         end
         for (int i = 0; i < 46; i++) begin
            vec++;
            if ({got_sym[i], got_tail[i], got_last[i]} !== {exp_sym[i], exp_tail[i], exp_last[i]}) begin
               errs++;
               $display("FAIL stall_sym pass %0d [%0d]: got %b expected %b", pass, i,
                        {got_sym[i], got_tail[i], got_last[i]}, {exp_sym[i], exp_tail[i], exp_last[i]});
            end
         end
      end
      vec++;
      if (viol !== 0 || stalls == 0) begin
         errs++;
         $display("FAIL stall_hold: got %0d changes over %0d stalled cycles expected 0 over >0",
                  viol, stalls);
      end
   endtask

   task automatic test_reset_mid();
      int got, viol, stalls;
      fill_blk(1);
      send_block(40, 3, 10);
      collect(17, 1'b0, got, viol, stalls);
      rst_i = 1'b1;
      @(negedge clk_i);
      vec++;
      if ({bit_ready_o, sym_valid_o, busy_o, sym_tail_o, sym_last_o} !== 5'b10000) begin
         errs++;
         $display("FAIL midreset_outputs: got %b expected 10000",
                  {bit_ready_o, sym_valid_o, busy_o, sym_tail_o, sym_last_o});
      end
      rst_i = 1'b0;
      sym_ready_i = 1'b0;
      fill_blk(1);
      build_model(40, 3, 10);
      send_block(40, 3, 10);
      collect(46, 1'b0, got, viol, stalls);
      for (int i = 0; i < 46; i++) begin
         vec++;
         if ({got_sym[i], got_tail[i], got_last[i]} !== {exp_sym[i], exp_tail[i], exp_last[i]}) begin
            errs++;
            $display("FAIL midreset_sym[%0d]: got %b expected %b", i,
                     {got_sym[i], got_tail[i], got_last[i]}, {exp_sym[i], exp_tail[i], exp_last[i]});
         end
      end
   endtask

   task automatic test_bad_len();
      int got, viol, stalls;
      @(negedge clk_i);
      bit_valid_i = 1'b1;
      bit_i       = 1'b1;
      blk_len_i   = AW'(5);
      @(negedge clk_i);
      bit_valid_i = 1'b0;
      vec++;
      if ({err_o, busy_o, bit_ready_o} !== 3'b101) begin
         errs++;
         $display("FAIL badlen_pulse: got %b expected 101", {err_o, busy_o, bit_ready_o});
      end
      @(negedge clk_i);
      vec++;
      if ({err_o, busy_o} !== 2'b00) begin
         errs++;
         $display("FAIL badlen_clear: got %b expected 00", {err_o, busy_o});
      end
      fill_blk(1);
      build_model(40, 3, 10);
      send_block(40, 3, 10);
      collect(46, 1'b0, got, viol, stalls);
      for (int i = 0; i < 46; i++) begin
         vec++;
         if ({got_sym[i], got_tail[i], got_last[i]} !== {exp_sym[i], exp_tail[i], exp_last[i]}) begin
            errs++;
            $display("FAIL badlen_sym[%0d]: got %b expected %b", i,
                     {got_sym[i], got_tail[i], got_last[i]}, {exp_sym[i], exp_tail[i], exp_last[i]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_block();
      test_impulse();
      test_interleaver();
      test_stall();
      test_reset_mid();
      test_bad_len();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
